// File: rtl/keypad_pkg.sv
// Shared types and key-map table for the keypad digit-entry block.
package keypad_pkg;

    localparam int MAX_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_SCAN         = 2'd0,
        ST_DEBOUNCE     = 2'd1,
        ST_EMIT         = 2'd2,
        ST_WAIT_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KC_NONE  = 2'd0,
        KC_DIGIT = 2'd1,
        KC_CLEAR = 2'd2,
        KC_ENTER = 2'd3
    } key_class_e;

    typedef struct packed {
        key_class_e cls;
        logic [3:0] value;
    } key_t;

    // Indexed by {row, col}; rows top to bottom, columns left to right.
    localparam key_t KEY_MAP [16] = '{
        '{KC_DIGIT, 4'd1}, '{KC_DIGIT, 4'd2}, '{KC_DIGIT, 4'd3}, '{KC_NONE,  4'd0},
        '{KC_DIGIT, 4'd4}, '{KC_DIGIT, 4'd5}, '{KC_DIGIT, 4'd6}, '{KC_NONE,  4'd0},
        '{KC_DIGIT, 4'd7}, '{KC_DIGIT, 4'd8}, '{KC_DIGIT, 4'd9}, '{KC_NONE,  4'd0},
        '{KC_CLEAR, 4'd0}, '{KC_DIGIT, 4'd0}, '{KC_ENTER, 4'd0}, '{KC_NONE,  4'd0}
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        casez (rows)
            4'b???0: lowest_low = 2'd0;
            4'b??01: lowest_low = 2'd1;
            4'b?011: lowest_low = 2'd2;
            default: lowest_low = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running divider: one-cycle scan_tick_o every SCAN_TICKS clocks.
module keypad_scan_tick #(
    parameter int SCAN_TICKS = 50000
) (
    input  logic CLK,
    input  logic RESET,
    output logic scan_tick_o
);
    localparam int CW = $clog2(SCAN_TICKS);

    logic [CW-1:0] cnt_q, cnt_d;

    assign scan_tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = scan_tick_o ? CW'(SCAN_TICKS - 1) : cnt_q - 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/keypad_digit_entry.sv
// 4x4 keypad scanner with debounce, digit accumulation and clear/enter pulses.
//   state           | meaning
//   ST_SCAN         | rotate the low column each tick until a row reads low
//   ST_DEBOUNCE     | column frozen, latched row must stay low DEBOUNCE_SCANS ticks
//   ST_EMIT         | single cycle carrying the registered output pulse
//   ST_WAIT_RELEASE | column frozen until all rows high DEBOUNCE_SCANS ticks
module keypad_digit_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 50000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] KEY_ROW,
    output logic [3:0] KEY_COL,
    output logic [3:0] Digit_out,
    output logic       Digit_valid,
    output logic       Clear_pulse,
    output logic       Enter_pulse,
    output logic [2:0] Digit_count,
    output logic       Entry_full
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    logic          scan_tick;
    logic [3:0]    row_meta_q, row_sync_q;
    state_e        state_q, state_d;
    logic [1:0]    col_q, col_d, row_q, row_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [3:0]    digit_q, digit_d;
    logic          valid_q, valid_d, clear_q, clear_d, enter_q, enter_d;
    logic [2:0]    count_q, count_d;
    logic          deb_last;
    key_t          key_hit;

    keypad_scan_tick #(.SCAN_TICKS(SCAN_TICKS)) u_scan_tick (
        .CLK         (CLK),
        .RESET       (RESET),
        .scan_tick_o (scan_tick)
    );

    assign key_hit  = KEY_MAP[{row_q, col_q}];
    assign deb_last = (deb_q == DW'(DEBOUNCE_SCANS - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        deb_d   = deb_q;
        digit_d = digit_q;
        count_d = count_q;
        valid_d = 1'b0;
        clear_d = 1'b0;
        enter_d = 1'b0;
        case (state_q)
            ST_SCAN: if (scan_tick) begin
                if (row_sync_q != 4'hF) begin
                    row_d   = lowest_low(row_sync_q);
                    deb_d   = '0;
                    state_d = ST_DEBOUNCE;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            ST_DEBOUNCE: if (scan_tick) begin
                if (row_sync_q[row_q]) begin
                    state_d = ST_SCAN;
                end else if (deb_last) begin
                    state_d = ST_EMIT;
                    case (key_hit.cls)
                        KC_DIGIT: if (count_q < 3'(MAX_DIGITS)) begin
                            valid_d = 1'b1;
                            digit_d = key_hit.value;
                        end
                        KC_CLEAR: clear_d = 1'b1;
                        KC_ENTER: enter_d = 1'b1;
                        default:  ;
                    endcase
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            ST_EMIT: begin
                state_d = ST_WAIT_RELEASE;
                deb_d   = '0;
                if (valid_q)            count_d = count_q + 3'd1;
                if (clear_q || enter_q) count_d = 3'd0;
            end
            ST_WAIT_RELEASE: if (scan_tick) begin
                // Any low row, including a second key, restarts the release window.
                if (row_sync_q != 4'hF) begin
                    deb_d = '0;
                end else if (deb_last) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = ST_SCAN;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            state_q    <= ST_SCAN;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
            deb_q      <= '0;
            digit_q    <= 4'd0;
            count_q    <= 3'd0;
            valid_q    <= 1'b0;
            clear_q    <= 1'b0;
            enter_q    <= 1'b0;
        end else begin
            row_meta_q <= KEY_ROW;
            row_sync_q <= row_meta_q;
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            deb_q      <= deb_d;
            digit_q    <= digit_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            clear_q    <= clear_d;
            enter_q    <= enter_d;
        end
    end

    assign KEY_COL     = ~(4'b0001 << col_q);
    assign Digit_out   = digit_q;
    assign Digit_valid = valid_q;
    assign Clear_pulse = clear_q;
    assign Enter_pulse = enter_q;
    assign Digit_count = count_q;
    assign Entry_full  = (count_q == 3'(MAX_DIGITS));
endmodule

// File: doc/keypad_digit_entry.md
KEYPAD_DIGIT_ENTRY -- requirements
Module: keypad_digit_entry

Interface
REQ-001 Parameter SCAN_TICKS, default 50000, CLK cycles per column-scan tick (1 ms at 50 MHz); legal range >= 4.
REQ-002 Parameter DEBOUNCE_SCANS, default 20, consecutive stable scan ticks required for press or release; legal range >= 2.
REQ-003 CLK  in  1  system clock, CLOCK_50; all logic on rising edge.
REQ-004 RESET  in  1  reset, asynchronous assert, active-high.
REQ-005 KEY_ROW  in  4  keypad rows, active-low, externally pulled up, asynchronous to CLK.
REQ-006 KEY_COL  out  4  column drive, active-low, exactly one bit low at any time.
REQ-007 Digit_out  out  4  last accepted digit 0-9, binary; drives the barcode shift register's digit input.
REQ-008 Digit_valid  out  1  one-cycle pulse when Digit_out is new; drives the barcode shift register's ENABLE.
REQ-009 Clear_pulse  out  1  one-cycle pulse on accepted '*' key.
REQ-010 Enter_pulse  out  1  one-cycle pulse on accepted '#' key.
REQ-011 Digit_count  out  3  digits accepted since last reset/clear/enter, 0-4.
REQ-012 Entry_full  out  1  high when Digit_count == 4.

Function
REQ-013 KEY_ROW shall pass through a two-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-014 Key map (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D; A-D shall be debounced but produce no output.
REQ-015 A free-running tick counter shall pulse scan_tick every SCAN_TICKS cycles; rows are sampled only on scan_tick.
REQ-016 FSM states: SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-017 SCAN: on scan_tick with all rows high, advance KEY_COL 1110->1101->1011->0111->1110; with any row low, latch column and lowest-index low row, clear debounce count, go DEBOUNCE without advancing.
REQ-018 DEBOUNCE: KEY_COL held; on scan_tick, latched row still low -> count+1, latched row high -> SCAN; count reaching DEBOUNCE_SCANS -> EMIT.
REQ-019 EMIT: lasts exactly one cycle, asserts the single applicable pulse, then WAIT_RELEASE.
REQ-020 WAIT_RELEASE: KEY_COL held; all rows high for DEBOUNCE_SCANS consecutive ticks -> SCAN with column advanced; any row low restarts the count; held key never repeats.
REQ-021 Digit key with Digit_count < 4: Digit_out updated and Digit_valid pulsed in the same cycle, Digit_count+1 next cycle; Digit_out holds until next accepted digit.
REQ-022 Digit key with Digit_count == 4: no Digit_valid, Digit_out and Digit_count unchanged.
REQ-023 '*': Clear_pulse, Digit_count->0; '#': Enter_pulse, Digit_count->0; both regardless of count, Digit_out unchanged.
REQ-024 Second key pressed while first held: ignored until full release per REQ-020.
REQ-025 Pulse outputs shall be registered; at most one of Digit_valid/Clear_pulse/Enter_pulse high in any cycle.

Reset
REQ-026 RESET high shall immediately force: state SCAN, KEY_COL 1110, tick and debounce counters 0, synchronizer flops 1111, Digit_out 0, all pulses 0, Digit_count 0, Entry_full 0.
REQ-027 RESET mid-DEBOUNCE/WAIT_RELEASE shall discard the pending key; a key still held after release of RESET shall be debounced afresh.

Structure
REQ-028 Package keypad_pkg shall hold the FSM state enum, 4x4 key-map table, key-class codes (DIGIT, CLEAR, ENTER, NONE) and MAX_DIGITS = 4.
REQ-029 Sub-module keypad_scan_tick (parameterised divider producing scan_tick) shall be instantiated once; all else in keypad_digit_entry.

Verification (SCAN_TICKS=4, DEBOUNCE_SCANS=3)
REQ-030 Press r1/c1 stable -> single Digit_valid with Digit_out=5, Digit_count=1; KEY_COL frozen until release.
REQ-031 Press r3/c1 with 2-tick bounce (low,high,low...) -> no pulse during bounce, one Digit_valid Digit_out=0 after 3 stable ticks.
REQ-032 Enter 1,2,3,4,5 -> four Digit_valid (1,2,3,4), Entry_full=1, fifth press no pulse, Digit_out stays 4.
REQ-033 Count=4 then press r3/c0 -> Clear_pulse, Digit_count=0; press r3/c2 -> Enter_pulse, count 0.
REQ-034 Hold r0/c0 for 50 ticks -> exactly one Digit_valid (Digit_out=1); press r0/c3 -> no output.
REQ-035 Assert RESET during DEBOUNCE of key 9 -> all outputs reset values at once, KEY_COL=1110, no Digit_valid for that press.
